// File: rtl/morse_decoder_if.sv
// rtl/morse_decoder_if.sv - Morse line in, decoded letter and status out
interface morse_decoder_if;
  logic       morse_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  modport master (output morse_in, input letter, letter_valid, letter_error, busy);
  modport slave  (input morse_in, output letter, letter_valid, letter_error, busy);
endinterface

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse decoder for letters S..Z
// Samples the line once per unit, mid-unit, realigning on every input edge.
module morse_decoder #(
  parameter int TICK_DIV = 25000000
) (
  input  logic            clock,
  input  logic            reset,
  morse_decoder_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] FULL_LOAD = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t        state;
  logic          prev;
  logic [TW-1:0] timer;
  logic [2:0]    run;
  logic [3:0]    elems;
  logic [2:0]    cnt;
  logic          err;

  logic       edge_seen;
  logic       sample_tick;
  logic       sampled;
  logic [3:0] dec;

  // Returns {hit, code}; the most recent element sits in bit 0.
  function automatic logic [3:0] decode(input logic [2:0] n, input logic [3:0] e);
    logic [3:0] r;
    r = 4'b0000;
    case (n)
      3'd1: if (e[0]) r = {1'b1, 3'd1};
      3'd3: case (e[2:0])
              3'b000:  r = {1'b1, 3'd0};
              3'b001:  r = {1'b1, 3'd2};
              3'b011:  r = {1'b1, 3'd4};
              default: r = 4'b0000;
            endcase
      3'd4: case (e)
              4'b0001: r = {1'b1, 3'd3};
              4'b1001: r = {1'b1, 3'd5};
              4'b1011: r = {1'b1, 3'd6};
              4'b1100: r = {1'b1, 3'd7};
              default: r = 4'b0000;
            endcase
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign edge_seen   = prev != bus.morse_in;
  assign sample_tick = !edge_seen && (timer == '0);
  assign sampled     = bus.morse_in;
  assign dec         = decode(cnt, elems);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      prev             <= 1'b0;
      timer            <= FULL_LOAD;
      run              <= 3'd0;
      elems            <= 4'd0;
      cnt              <= 3'd0;
      err              <= 1'b0;
      bus.letter       <= 3'd0;
      bus.letter_valid <= 1'b0;
      bus.letter_error <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      prev             <= bus.morse_in;
      bus.letter_valid <= 1'b0;
      bus.letter_error <= 1'b0;

      if (edge_seen)
        timer <= HALF_LOAD;
      else if (timer == '0)
        timer <= FULL_LOAD;
      else
        timer <= timer - 1'b1;

      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (sampled) begin
              state    <= MARK;
              run      <= 3'd1;
              elems    <= 4'd0;
              cnt      <= 3'd0;
              err      <= 1'b0;
              bus.busy <= 1'b1;
            end
          end
          MARK: begin
            if (sampled) begin
              if (run != 3'd7) run <= run + 3'd1;
            end else begin
              // A malformed mark is still appended so the count stays honest.
              elems <= {elems[2:0], run == 3'd3};
              err   <= err | !((run == 3'd1) || (run == 3'd3)) | (cnt == 3'd4);
              if (cnt != 3'd4) cnt <= cnt + 3'd1;
              state <= SPACE;
              run   <= 3'd1;
            end
          end
          SPACE: begin
            if (sampled) begin
              if (run == 3'd2) err <= 1'b1;
              state <= MARK;
              run   <= 3'd1;
            end else if (run == 3'd2) begin
              if (dec[3] && !err) begin
                bus.letter       <= dec[2:0];
                bus.letter_valid <= 1'b1;
              end else begin
                bus.letter_error <= 1'b1;
              end
              state    <= IDLE;
              run      <= 3'd0;
              bus.busy <= 1'b0;
            end else begin
              run <= run + 3'd1;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
